// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, instruction
// field positions, flag bit indices, FSM states and the LDI flag helper.
package alu_op_sequencer_pkg;

   localparam int unsigned ALU_W   = 4;
   localparam int unsigned INSTR_W = 12;

   localparam logic [3:0] OP_CLR = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_LDI = 4'b1000;
   localparam logic [3:0] OP_ILL = 4'b1111;

   localparam int unsigned OP_MSB  = 11;
   localparam int unsigned OP_LSB  = 8;
   localparam int unsigned RD_MSB  = 7;
   localparam int unsigned RD_LSB  = 6;
   localparam int unsigned RA_MSB  = 5;
   localparam int unsigned RA_LSB  = 4;
   localparam int unsigned RB_MSB  = 3;
   localparam int unsigned RB_LSB  = 2;
   localparam int unsigned IMM_MSB = 5;
   localparam int unsigned IMM_LSB = 2;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_e;

   // LDI sets Z and N from the immediate and clears C and V
   function automatic logic [3:0] ldi_flags(input logic [3:0] imm);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = (imm == 4'd0);
      f[FLAG_N] = imm[3];
      return f;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction and response handshake channels of the ALU sequencer.
// master = instruction source / response consumer, slave = sequencer.
interface alu_op_sequencer_if;
   import alu_op_sequencer_pkg::*;

   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;
   logic               res_valid;
   logic               res_ready;
   logic [ALU_W-1:0]   res_data;
   logic [ALU_W-1:0]   res_flags;
   logic               res_err;

   modport master (
      output instr_valid, instr, res_ready,
      input  instr_ready, res_valid, res_data, res_flags, res_err
   );

   modport slave (
      input  instr_valid, instr, res_ready,
      output instr_ready, res_valid, res_data, res_flags, res_err
   );

endinterface

// File: rtl/alu_op_sequencer_regfile.sv
// seq_regfile: 2^REG_AW x DATA_W register file, two combinational operand
// read ports, one combinational debug read port, one synchronous write port.
module seq_regfile #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [REG_AW-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int unsigned NREG = 1 << REG_AW;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];

   // Next register contents: single-entry write
   always_comb begin
      regs_d = regs_q;
      if (we) begin
         regs_d[waddr] = wdata;
      end
   end

   // Register storage with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign ra_data  = regs_q[ra_addr];
   assign rb_data  = regs_q[rb_addr];
   assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: fetches one instruction per handshake, reads operands,
// drives the external ALU for one cycle, writes back and returns a response.
// Optional statistics counters enabled by defining ALU_SEQ_STATS_EN.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned REG_AW = 2,
   parameter int unsigned STAT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_op_sequencer_if.slave bus,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_c,
   input  logic [3:0]        alu_cond,
   output logic [3:0]        flags,
`ifdef ALU_SEQ_STATS_EN
   output logic [STAT_W-1:0] stat_ops,
   output logic [STAT_W-1:0] stat_err,
`endif
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   if (DATA_W != ALU_W) begin : g_bad_width
      $error("alu_op_sequencer supports DATA_W == 4 only");
   end
   if (STAT_W == 0) begin : g_bad_stat
      $error("alu_op_sequencer requires STAT_W >= 1");
   end

   seq_state_e         state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [3:0]         alu_op_q, alu_op_d;
   logic [DATA_W-1:0]  alu_a_q, alu_a_d;
   logic [DATA_W-1:0]  alu_b_q, alu_b_d;
   logic [3:0]         flags_q, flags_d;
   logic [DATA_W-1:0]  res_data_q, res_data_d;
   logic [3:0]         res_flags_q, res_flags_d;
   logic               res_err_q, res_err_d;

   logic               rf_we;
   logic [REG_AW-1:0]  rf_waddr;
   logic [DATA_W-1:0]  rf_wdata;
   logic [DATA_W-1:0]  rf_ra_data, rf_rb_data;
   logic [3:0]         exec_op;
   logic [3:0]         in_op;
   logic [3:0]         imm;
   logic [1:0]         unused_instr_bits;

   assign exec_op           = instr_q[OP_MSB:OP_LSB];
   assign in_op             = bus.instr[OP_MSB:OP_LSB];
   assign imm               = instr_q[IMM_MSB:IMM_LSB];
   assign unused_instr_bits = instr_q[1:0];

   // Operands are read at accept time; the previous writeback has already
   // landed because a response cycle always separates two EXEC cycles.
   seq_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .ra_addr  (bus.instr[RA_MSB:RA_LSB]),
      .ra_data  (rf_ra_data),
      .rb_addr  (bus.instr[RB_MSB:RB_LSB]),
      .rb_data  (rf_rb_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   assign bus.instr_ready = (state_q == ST_IDLE) && rst_n;

   // Sequencer next state, operand capture, writeback and response load
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      flags_d     = flags_q;
      res_data_d  = res_data_q;
      res_flags_d = res_flags_q;
      res_err_d   = res_err_q;
      rf_we       = 1'b0;
      rf_waddr    = instr_q[RD_MSB:RD_LSB];
      rf_wdata    = alu_c;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.instr_valid && bus.instr_ready) begin
               instr_d  = bus.instr;
               alu_op_d = (in_op == OP_LDI) ? OP_CLR : in_op;
               alu_a_d  = rf_ra_data;
               alu_b_d  = rf_rb_data;
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (exec_op == OP_ILL) begin
               res_data_d  = '0;
               res_flags_d = flags_q;
               res_err_d   = 1'b1;
            end else if (exec_op == OP_LDI) begin
               rf_we       = 1'b1;
               rf_wdata    = imm;
               flags_d     = ldi_flags(imm);
               res_data_d  = imm;
               res_flags_d = ldi_flags(imm);
               res_err_d   = 1'b0;
            end else begin
               rf_we       = 1'b1;
               rf_wdata    = alu_c;
               flags_d     = alu_cond;
               res_data_d  = alu_c;
               res_flags_d = alu_cond;
               res_err_d   = 1'b0;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         instr_q     <= '0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         flags_q     <= '0;
         res_data_q  <= '0;
         res_flags_q <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         flags_q     <= flags_d;
         res_data_q  <= res_data_d;
         res_flags_q <= res_flags_d;
         res_err_q   <= res_err_d;
      end
   end

   assign bus.res_valid = (state_q == ST_RESP);
   assign bus.res_data  = res_data_q;
   assign bus.res_flags = res_flags_q;
   assign bus.res_err   = res_err_q;
   assign alu_op        = alu_op_q;
   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign flags         = flags_q;

`ifdef ALU_SEQ_STATS_EN
   logic [STAT_W-1:0] stat_ops_q, stat_ops_d;
   logic [STAT_W-1:0] stat_err_q, stat_err_d;

   // Saturating response counters, stepped on the response handshake
   always_comb begin
      stat_ops_d = stat_ops_q;
      stat_err_d = stat_err_q;
      if (bus.res_valid && bus.res_ready) begin
         if (stat_ops_q != '1) begin
            stat_ops_d = stat_ops_q + 1'b1;
         end
         if (res_err_q && (stat_err_q != '1)) begin
            stat_err_d = stat_err_q + 1'b1;
         end
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops_q <= '0;
         stat_err_q <= '0;
      end else begin
         stat_ops_q <= stat_ops_d;
         stat_err_q <= stat_err_d;
      end
   end

   assign stat_ops = stat_ops_q;
   assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer with a behavioural 4-bit ALU attached.
// Statistics checks compile in when ALU_SEQ_STATS_EN is defined.
module tb_alu_op_sequencer;
   import alu_op_sequencer_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [3:0] alu_op, alu_a, alu_b, alu_c, alu_cond, flags;
   logic [1:0] dbg_addr;
   logic [3:0] dbg_data;
`ifdef ALU_SEQ_STATS_EN
   logic [7:0] stat_ops, stat_err;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   int n_acc  = 0;

   alu_op_sequencer_if bus ();

   alu_op_sequencer #(
      .DATA_W (4),
      .REG_AW (2),
      .STAT_W (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .alu_op   (alu_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_c    (alu_c),
      .alu_cond (alu_cond),
      .flags    (flags),
`ifdef ALU_SEQ_STATS_EN
      .stat_ops (stat_ops),
      .stat_err (stat_err),
`endif
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: ADD, SUB (C = no borrow), AND, else pass A
   logic [4:0] alu_s;
   logic       alu_cf, alu_vf;
   always_comb begin
      alu_s  = '0;
      alu_c  = alu_a;
      alu_cf = 1'b0;
      alu_vf = 1'b0;
      case (alu_op)
         4'b0001: begin
            alu_s  = {1'b0, alu_a} + {1'b0, alu_b};
            alu_c  = alu_s[3:0];
            alu_cf = alu_s[4];
            alu_vf = (alu_a[3] == alu_b[3]) && (alu_c[3] != alu_a[3]);
         end
         4'b0010: begin
            alu_s  = {1'b0, alu_a} - {1'b0, alu_b};
            alu_c  = alu_s[3:0];
            alu_cf = ~alu_s[4];
            alu_vf = (alu_a[3] != alu_b[3]) && (alu_c[3] != alu_a[3]);
         end
         4'b0011: alu_c = alu_a & alu_b;
         default: alu_c = alu_a;
      endcase
      alu_cond = {alu_c == 4'd0, alu_c[3], alu_cf, alu_vf};
   end

   always @(posedge clk) begin
      if (bus.instr_valid && bus.instr_ready) n_acc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Issue one instruction and collect its response (res_ready held high)
   task automatic run_instr(input logic [11:0] i, output logic [3:0] d,
                            output logic [3:0] f, output logic e);
      bit got;
      d = '0; f = '0; e = 1'b0;
      bus.instr = i; bus.instr_valid = 1'b1; bus.res_ready = 1'b1;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (bus.instr_ready) got = 1;
      end
      chk("accept_in_time", 32'(got), 32'd1);
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      chk("no_resp_after_accept", 32'(bus.res_valid), 32'd0);
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (bus.res_valid) begin
            got = 1; d = bus.res_data; f = bus.res_flags; e = bus.res_err;
         end
      end
      chk("response_in_time", 32'(got), 32'd1);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [11:0] instr;
      logic [3:0]  exp_data;
      logic [3:0]  exp_flags;
      logic        exp_err;
      logic [1:0]  dbg;
      logic [3:0]  exp_dbg;
   } vec_t;

   vec_t       vecs [11];
   logic [3:0] d, f;
   logic       e;
   int         acc0;

   initial begin
      rst_n = 1'b0; dbg_addr = '0;
      bus.instr_valid = 1'b0; bus.instr = '0; bus.res_ready = 1'b0;

      //          instr              data   flags    err  dbg   R[dbg]
      vecs[0]  = '{12'b1000_01_0011_00, 4'd3,  4'b0000, 1'b0, 2'd1, 4'd3};  // LDI R1,#3
      vecs[1]  = '{12'b1000_10_0101_00, 4'd5,  4'b0000, 1'b0, 2'd2, 4'd5};  // LDI R2,#5
      vecs[2]  = '{12'b0001_00_01_10_00, 4'd8, 4'b0101, 1'b0, 2'd0, 4'd8};  // ADD R0,R1,R2
      vecs[3]  = '{12'b1111_11_00_00_00, 4'd0, 4'b0101, 1'b1, 2'd0, 4'd8};  // illegal
      vecs[4]  = '{12'b0010_11_01_01_00, 4'd0, 4'b1010, 1'b0, 2'd3, 4'd0};  // SUB R3,R1,R1
      vecs[5]  = '{12'b1000_10_0000_00, 4'd0,  4'b1000, 1'b0, 2'd2, 4'd0};  // LDI R2,#0
      vecs[6]  = '{12'b1000_01_1111_00, 4'd15, 4'b0100, 1'b0, 2'd1, 4'd15}; // LDI R1,#15
      vecs[7]  = '{12'b0001_01_01_01_00, 4'd14, 4'b0110, 1'b0, 2'd1, 4'd14};// ADD R1,R1,R1
      vecs[8]  = '{12'b0010_10_10_01_00, 4'd2, 4'b0000, 1'b0, 2'd2, 4'd2};  // SUB R2,R2,R1
      vecs[9]  = '{12'b1000_11_1000_00, 4'd8,  4'b0100, 1'b0, 2'd3, 4'd8};  // LDI R3,#8
      vecs[10] = '{12'b0001_00_11_11_00, 4'd0, 4'b1011, 1'b0, 2'd0, 4'd0};  // ADD R0,R3,R3

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_data", 32'(bus.res_data), 32'd0);
      chk("rst_res_flags", 32'(bus.res_flags), 32'd0);
      chk("rst_res_err", 32'(bus.res_err), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_release", 32'(bus.instr_ready), 32'd1);

      // Table-driven instruction stream
      for (int v = 0; v < 11; v++) begin
         run_instr(vecs[v].instr, d, f, e);
         chk($sformatf("v%0d_res_data", v), 32'(d), 32'(vecs[v].exp_data));
         chk($sformatf("v%0d_res_flags", v), 32'(f), 32'(vecs[v].exp_flags));
         chk($sformatf("v%0d_res_err", v), 32'(e), 32'(vecs[v].exp_err));
         chk($sformatf("v%0d_flags", v), 32'(flags), 32'(vecs[v].exp_flags));
         dbg_addr = vecs[v].dbg; #1;
         chk($sformatf("v%0d_dbg", v), 32'(dbg_data), 32'(vecs[v].exp_dbg));
      end

      // Response stall: res_ready low for 5 cycles, instr_valid held high
      acc0 = n_acc;
      bus.instr = 12'b0001_00_01_10_00;  // ADD R0,R1,R2 = 14+2 -> 0
      bus.instr_valid = 1'b1; bus.res_ready = 1'b0;
      for (int k = 0; k < 20 && !bus.res_valid; k++) @(negedge clk);
      chk("stall_resp_seen", 32'(bus.res_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_res_valid", 32'(bus.res_valid), 32'd1);
         chk("stall_res_data", 32'(bus.res_data), 32'd0);
         chk("stall_res_flags", 32'(bus.res_flags), 32'b1010);
         chk("stall_instr_ready", 32'(bus.instr_ready), 32'd0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      chk("stall_released", 32'(bus.res_valid), 32'd0);
      chk("stall_one_accept", 32'(n_acc - acc0), 32'd1);
      dbg_addr = 2'd0; #1;
      chk("stall_r0", 32'(dbg_data), 32'd0);

      // Reset during EXEC of LDI R1,#7
      bus.instr = 12'b1000_01_0111_00; bus.instr_valid = 1'b1;
      for (int k = 0; k < 20 && !bus.instr_ready; k++) @(negedge clk);
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("midrst_instr_ready", 32'(bus.instr_ready), 32'd0);
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready_after", 32'(bus.instr_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_no_resp", 32'(bus.res_valid), 32'd0);
      chk("midrst_flags", 32'(flags), 32'd0);
      dbg_addr = 2'd1; #1;
      chk("midrst_r1", 32'(dbg_data), 32'd0);
      dbg_addr = 2'd3; #1;
      chk("midrst_r3", 32'(dbg_data), 32'd0);

      // 4 legal + 1 illegal after reset
      run_instr(12'b1000_00_0001_00, d, f, e);  // LDI R0,#1
      chk("s_ldi0", 32'(d), 32'd1);
      run_instr(12'b1000_01_0010_00, d, f, e);  // LDI R1,#2
      chk("s_ldi1", 32'(d), 32'd2);
      run_instr(12'b0001_10_00_01_00, d, f, e); // ADD R2,R0,R1
      chk("s_add", 32'(d), 32'd3);
      chk("s_add_flags", 32'(f), 32'b0000);
      run_instr(12'b1111_00_00_00_00, d, f, e); // illegal
      chk("s_ill_err", 32'(e), 32'd1);
      chk("s_ill_data", 32'(d), 32'd0);
      dbg_addr = 2'd0; #1;
      chk("s_ill_r0_kept", 32'(dbg_data), 32'd1);
      run_instr(12'b0010_11_01_00_00, d, f, e); // SUB R3,R1,R0
      chk("s_sub", 32'(d), 32'd1);
      chk("s_sub_flags", 32'(f), 32'b0010);
`ifdef ALU_SEQ_STATS_EN
      chk("stat_ops", 32'(stat_ops), 32'd5);
      chk("stat_err", 32'(stat_err), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
